// File: rtl/p_beid_interconnect_f0_ahb_to_apb_seq.sv
// AHB-Lite to APB sequencer for the matrix APB0 target port.
// Handles one AHB transfer at a time and runs APB SETUP/ACCESS to one of NUM_PSEL slaves.
module p_beid_interconnect_f0_ahb_to_apb_seq #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_PSEL   = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [NUM_PSEL-1:0]   PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int IDX_W = ADDR_WIDTH - 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           start_state;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] haddr_idx;
  logic             access_done;
  logic             accept;
  logic             misaligned;
  logic             size_bad;
  logic             idx_bad;
  logic             req_err;
  logic             in_apb;
  logic             unused;

  assign unused    = HTRANS[0];
  assign haddr_idx = HADDR[ADDR_WIDTH-1:12];

  // A new transfer may only start when the previous one is fully retired.
  assign access_done = (state == ST_ACCESS) & PREADY & ~PSLVERR;
  assign accept      = ((state == ST_IDLE) | (state == ST_ERR2) | access_done)
                       & HSEL & HTRANS[1] & HREADY;

  assign misaligned = ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
                      ((HSIZE == 3'd1) && HADDR[0]);
  assign size_bad   = (HSIZE > 3'd2);
  assign idx_bad    = (32'(haddr_idx) >= 32'(NUM_PSEL));
  assign req_err    = misaligned | size_bad | idx_bad;

  assign start_state = req_err ? ST_ERR1 : (HWRITE ? ST_WWAIT : ST_SETUP);
  assign in_apb      = (state == ST_SETUP) | (state == ST_ACCESS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    PENABLE   = 1'b0;
    PSEL      = '0;

    case (state)
      ST_IDLE: begin
        HREADYOUT = 1'b1;
        state_nxt = accept ? start_state : ST_IDLE;
      end
      ST_WWAIT: state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        PENABLE = 1'b1;
        if (!PWRITE) HRDATA = PRDATA;
        if (PREADY) begin
          if (PSLVERR) begin
            state_nxt = ST_ERR1;
          end else begin
            HREADYOUT = 1'b1;
            state_nxt = accept ? start_state : ST_IDLE;
          end
        end
      end
      ST_ERR1: begin
        HRESP     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
        state_nxt = accept ? start_state : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    for (int i = 0; i < NUM_PSEL; i++) begin
      PSEL[i] = in_apb && (idx_q == IDX_W'(i));
    end
  end

  // APB address/control hold their last values between transfers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= 32'h0;
      idx_q  <= '0;
    end else begin
      if (accept) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        idx_q  <= haddr_idx;
      end
      if (state == ST_WWAIT) begin
        PWDATA <= HWDATA;
      end
    end
  end

endmodule
